if_id_pipe: RTL and testbench
=============================

IF_ID_PIPE -- requirements
Module: if_id_pipe

Interface
REQ-001 Parameter PC_W, 32, PC field width in bits.
REQ-002 Parameter INST_W, 32, instruction field width in bits.
REQ-003 Parameter NOP_INST, 32'h0000_0013, bubble instruction driven on id_inst when no valid entry is present; width INST_W.
REQ-004 Port clk  input  1  single clock; all state updates on rising edge.
REQ-005 Port rst  input  1  synchronous, active-high reset.
REQ-006 Port if_valid  input  1  fetch presents a valid PC/instruction pair.
REQ-007 Port if_ready  output  1  stage can accept; a transfer occurs when if_valid and if_ready are both high.
REQ-008 Port if_pc  input  PC_W  fetch PC.
REQ-009 Port if_inst  input  INST_W  fetch instruction.
REQ-010 Port flush  input  1  discard all held and incoming entries (branch/exception redirect).
REQ-011 Port id_valid  output  1  decode-side entry valid.
REQ-012 Port id_ready  input  1  decode accepts; a transfer occurs when id_valid and id_ready are both high.
REQ-013 Port id_pc  output  PC_W  registered PC of the head entry.
REQ-014 Port id_inst  output  INST_W  registered instruction of the head entry, NOP_INST when id_valid is low.
REQ-015 Port flush_cnt  output  16  saturating count of valid entries discarded by flush.

Function
REQ-016 The block SHALL hold a main register (drives id_*) and, with IF_ID_SKID_EN, one skid register; states EMPTY, BUSY (main only), FULL (main+skid).
REQ-017 Transitions: EMPTY->BUSY on input transfer; BUSY->EMPTY on output transfer without input; BUSY->BUSY on simultaneous input and output transfer (main reloaded with input); BUSY->FULL on input without output (input captured in skid); FULL->BUSY on output transfer (skid moved to main).
REQ-018 The block SHALL present latency of exactly one cycle from input transfer to id_valid high when in EMPTY or BUSY with simultaneous output.
REQ-019 With IF_ID_SKID_EN, if_ready SHALL be a registered signal, high in EMPTY and BUSY, low in FULL; no combinational path from id_ready to if_ready.
REQ-020 Entries SHALL leave in acceptance order; no entry duplicated or dropped except by flush.
REQ-021 id_pc/id_inst SHALL remain stable while id_valid is high and id_ready is low.
REQ-022 flush SHALL take priority over every transfer: next state EMPTY, id_valid low, id_inst NOP_INST, id_pc 0, and any input offered in the flush cycle discarded.
REQ-023 On flush, flush_cnt SHALL increase by the number of valid entries discarded (0, 1 or 2, excluding the discarded input), saturating at 16'hFFFF.
REQ-024 if_ready SHALL be high in the cycle after flush.

Reset
REQ-025 On rst, state EMPTY, id_valid 0, id_pc 0, id_inst NOP_INST, if_ready 1 (skid build) or driven by REQ-028, flush_cnt 0, skid contents don't-care.
REQ-026 rst SHALL take priority over flush and over any transfer, including mid-stall in FULL.

Configuration
REQ-027 Macro IF_ID_SKID_EN defined: skid register and FULL state compiled in, behaviour per REQ-016..REQ-019.
REQ-028 Macro IF_ID_SKID_EN undefined: no skid register, no FULL state; if_ready = id_ready OR NOT id_valid combinationally; flush_cnt increments by at most 1; all other requirements unchanged.

Structure
REQ-029 A shared package SHALL hold the state enumeration (EMPTY/BUSY/FULL) and the default NOP_INST constant for reuse by ID_EX and later stage registers.
REQ-030 One sub-module SHALL be used: pipe_skid_reg, a generic width-parameterised valid/ready register with optional skid; if_id_pipe wraps it with PC/instruction packing, NOP substitution, flush, and flush_cnt.

Verification
REQ-031 Reset then if_valid=1, if_pc=32'h100, if_inst=32'h00A00093, id_ready=1 -> next cycle id_valid=1, id_pc=32'h100, id_inst=32'h00A00093.
REQ-032 Stream PCs 0x0,0x4,0x8 with id_ready held 0 from cycle 1 (skid build) -> state FULL after two transfers, if_ready=0, id_pc stays 0x0; release id_ready -> outputs 0x0,0x4,0x8 in order, none lost.
REQ-033 FULL state, assert flush with if_valid=1 -> next cycle id_valid=0, id_inst=32'h00000013, flush_cnt=2, if_ready=1; offered input never appears at output.
REQ-034 Preload flush_cnt to 16'hFFFE via 1-entry flushes, then flush in FULL -> flush_cnt=16'hFFFF, holds on further flushes.
REQ-035 rst asserted in FULL with flush=1 and if_valid=1 -> next cycle id_valid=0, id_pc=0, flush_cnt=0, if_ready=1.
REQ-036 Build without IF_ID_SKID_EN, id_valid=1, toggle id_ready 0->1 -> if_ready follows id_ready in the same cycle; throughput one entry per cycle with id_ready=1.

Source files
------------

// File: rtl/if_id_pipe_pkg.sv
// Shared definitions for the pipeline stage registers (IF/ID, ID/EX, ...).
// Holds the occupancy state encoding, the default bubble instruction and a
// saturating counter helper.
package if_id_pipe_pkg;

    // Occupancy of a stage register: nothing held, main only, main plus skid
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_BUSY  = 2'd1,
        ST_FULL  = 2'd2
    } pipe_state_t;

    // RISC-V canonical NOP (addi x0, x0, 0) used as the bubble instruction
    localparam logic [31:0] DEFAULT_NOP_INST = 32'h0000_0013;

    // 16-bit add that clamps at all-ones instead of wrapping
    function automatic logic [15:0] sat_add16(input logic [15:0] a, input logic [1:0] b);
        logic [16:0] sum;
        sum = {1'b0, a} + {15'b0, b};
        return sum[16] ? 16'hFFFF : sum[15:0];
    endfunction

endpackage

// File: rtl/pipe_skid_reg.sv
// Generic valid/ready pipeline register of width W.
// Optional skid buffer selected by the IF_ID_SKID_EN macro:
//   defined   - main + skid register, registered in_ready (no ready path
//               from out_ready to in_ready)
//   undefined - single main register, in_ready = out_ready | ~out_valid
// flush empties the register; drop_cnt reports how many valid entries a
// flush in the current cycle would discard.
module pipe_skid_reg
    import if_id_pipe_pkg::*;
#(
    parameter int W = 64
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         flush,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data,
    output logic [1:0]   drop_cnt
);

    pipe_state_t  state_reg;
    logic [W-1:0] main_reg;
    logic         in_xfer;
    logic         out_xfer;

    assign out_valid = (state_reg != ST_EMPTY);
    assign out_data  = main_reg;
    assign in_xfer   = in_valid & in_ready;
    assign out_xfer  = out_valid & out_ready;

`ifdef IF_ID_SKID_EN

    logic [W-1:0] skid_reg;
    logic         ready_reg;

    assign in_ready = ready_reg;
    assign drop_cnt = (state_reg == ST_FULL) ? 2'd2 :
                      (state_reg == ST_BUSY) ? 2'd1 : 2'd0;

    // Occupancy FSM: main/skid loading, skid-to-main promotion, registered ready
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            state_reg <= ST_EMPTY;
            main_reg  <= '0;
            ready_reg <= 1'b1;
        end else begin
            case (state_reg)
                ST_EMPTY: begin
                    if (in_xfer) begin
                        main_reg  <= in_data;
                        state_reg <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    if (in_xfer && out_xfer) begin
                        main_reg <= in_data;
                    end else if (in_xfer) begin
                        // Downstream stalled: park the new entry behind the head
                        skid_reg  <= in_data;
                        state_reg <= ST_FULL;
                        ready_reg <= 1'b0;
                    end else if (out_xfer) begin
                        state_reg <= ST_EMPTY;
                    end
                end
                ST_FULL: begin
                    // in_ready is low here, so only the output side can move
                    if (out_xfer) begin
                        main_reg  <= skid_reg;
                        state_reg <= ST_BUSY;
                        ready_reg <= 1'b1;
                    end
                end
                default: begin
                    state_reg <= ST_EMPTY;
                    ready_reg <= 1'b1;
                end
            endcase
        end
    end

`else

    assign in_ready = out_ready | ~out_valid;
    assign drop_cnt = {1'b0, out_valid};

    // Single-entry register: load on accept, empty when drained without refill
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            state_reg <= ST_EMPTY;
            main_reg  <= '0;
        end else if (in_xfer) begin
            main_reg  <= in_data;
            state_reg <= ST_BUSY;
        end else if (out_xfer) begin
            state_reg <= ST_EMPTY;
        end
    end

`endif

endmodule

// File: rtl/if_id_pipe.sv
// IF/ID stage register. Packs fetch PC and instruction into a generic
// pipe_skid_reg, substitutes the bubble instruction when empty, handles
// redirect flushes and counts discarded entries (saturating).
// Optional skid buffer: define IF_ID_SKID_EN.
module if_id_pipe
    import if_id_pipe_pkg::*;
#(
    parameter int                PC_W     = 32,
    parameter int                INST_W   = 32,
    parameter logic [INST_W-1:0] NOP_INST = INST_W'(DEFAULT_NOP_INST)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_valid,
    output logic              if_ready,
    input  logic [PC_W-1:0]   if_pc,
    input  logic [INST_W-1:0] if_inst,
    input  logic              flush,
    output logic              id_valid,
    input  logic              id_ready,
    output logic [PC_W-1:0]   id_pc,
    output logic [INST_W-1:0] id_inst,
    output logic [15:0]       flush_cnt
);

    localparam int W = PC_W + INST_W;

    logic [W-1:0] in_data;
    logic [W-1:0] out_data;
    logic         out_valid;
    logic [1:0]   drop_cnt;
    logic [15:0]  flush_cnt_reg;

    assign in_data = {if_pc, if_inst};

    pipe_skid_reg #(
        .W (W)
    ) u_reg (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (if_valid),
        .in_ready  (if_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (id_ready),
        .out_data  (out_data),
        .drop_cnt  (drop_cnt)
    );

    assign id_valid  = out_valid;
    assign id_pc     = out_data[W-1:INST_W];
    assign id_inst   = out_valid ? out_data[INST_W-1:0] : NOP_INST;
    assign flush_cnt = flush_cnt_reg;

    // Count held entries thrown away by a flush; the offered input is not counted
    always_ff @(posedge clk) begin
        if (rst) begin
            flush_cnt_reg <= '0;
        end else if (flush) begin
            flush_cnt_reg <= sat_add16(flush_cnt_reg, drop_cnt);
        end
    end

endmodule

// File: tb/tb_if_id_pipe.sv
// Self-checking bench for if_id_pipe (works with or without IF_ID_SKID_EN).
// Stimulus pushes every accepted entry into a scoreboard queue; a monitor
// pops and compares whenever the decode side takes an entry.
module tb_if_id_pipe;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_valid;
    logic        if_ready;
    logic [31:0] if_pc;
    logic [31:0] if_inst;
    logic        flush;
    logic        id_valid;
    logic        id_ready;
    logic [31:0] id_pc;
    logic [31:0] id_inst;
    logic [15:0] flush_cnt;

`ifdef IF_ID_SKID_EN
    localparam int MAXDROP = 2;
`else
    localparam int MAXDROP = 1;
`endif

    logic [63:0] exp_q[$];
    logic [63:0] exp_e;
    logic [15:0] exp_fcnt;
    logic        last_acc;
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    if_id_pipe dut (
        .clk       (clk),
        .rst       (rst),
        .if_valid  (if_valid),
        .if_ready  (if_ready),
        .if_pc     (if_pc),
        .if_inst   (if_inst),
        .flush     (flush),
        .id_valid  (id_valid),
        .id_ready  (id_ready),
        .id_pc     (id_pc),
        .id_inst   (id_inst),
        .flush_cnt (flush_cnt)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] mk_inst(input int k);
        logic [31:0] r;
        r = 32'h0000_0093;
        r[31:20] = 12'(k);
        return r;
    endfunction

    // One clock cycle of stimulus; records accepted entries in the scoreboard
    task automatic cyc(input logic v, input logic [31:0] pc, input logic [31:0] inst,
                       input logic rdy, input logic fl);
        if_valid = v;
        if_pc    = pc;
        if_inst  = inst;
        id_ready = rdy;
        flush    = fl;
        @(negedge clk);
        last_acc = 1'b0;
        if (rst || fl) begin
            exp_q.delete();
        end else if (v && if_ready) begin
            exp_q.push_back({pc, inst});
            last_acc = 1'b1;
        end
        @(posedge clk);
        #1;
    endtask

    function automatic logic [15:0] sat_model(input logic [15:0] a, input int d);
        int t;
        t = int'(a) + d;
        return (t > 65535) ? 16'hFFFF : 16'(t);
    endfunction

    // Monitor: every decode-side transfer must match the oldest accepted entry
    always @(negedge clk) begin
        if (!rst && !flush && id_valid && id_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL out_unexpected: got pc=%h inst=%h expected no transfer", id_pc, id_inst);
            end else begin
                exp_e = exp_q.pop_front();
                if ({id_pc, id_inst} !== exp_e) begin
                    errors++;
                    $display("FAIL out_order: got pc=%h inst=%h expected pc=%h inst=%h",
                             id_pc, id_inst, exp_e[63:32], exp_e[31:0]);
                end else begin
                    $display("xfer pc=%h inst=%h", id_pc, id_inst);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int k;
        rst      = 1'b1;
        if_valid = 1'b0;
        if_pc    = '0;
        if_inst  = '0;
        flush    = 1'b0;
        id_ready = 1'b0;
        last_acc = 1'b0;
        exp_fcnt = 16'h0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        // Reset state
        chk("rst_id_valid", 32'(id_valid), 32'd0);
        chk("rst_id_pc", id_pc, 32'h0);
        chk("rst_id_inst", id_inst, 32'h0000_0013);
        chk("rst_flush_cnt", 32'(flush_cnt), 32'd0);
        chk("rst_if_ready", 32'(if_ready), 32'd1);

        // Single transfer, one cycle latency
        cyc(1'b1, 32'h100, 32'h00A0_0093, 1'b1, 1'b0);
        chk("lat_id_valid", 32'(id_valid), 32'd1);
        chk("lat_id_pc", id_pc, 32'h100);
        chk("lat_id_inst", id_inst, 32'h00A0_0093);
        cyc(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        chk("drain_id_valid", 32'(id_valid), 32'd0);
        chk("drain_id_inst", id_inst, 32'h0000_0013);

        // Ready follow (single-register build) and full throughput
        cyc(1'b1, 32'h10, mk_inst(0), 1'b0, 1'b0);
`ifndef IF_ID_SKID_EN
        if_valid = 1'b0;
        id_ready = 1'b0;
        #1;
        chk("follow_if_ready_lo", 32'(if_ready), 32'd0);
        id_ready = 1'b1;
        #1;
        chk("follow_if_ready_hi", 32'(if_ready), 32'd1);
`endif
        for (int i = 1; i <= 4; i++) begin
            cyc(1'b1, 32'h10 + 32'(i * 4), mk_inst(i), 1'b1, 1'b0);
            chk("tput_accept", 32'(last_acc), 32'd1);
            chk("tput_if_ready", 32'(if_ready), 32'd1);
        end
        cyc(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

        // Stall with stream 0x0, 0x4, 0x8; release after three cycles
        k = 0;
        for (int c = 0; c < 8; c++) begin
            cyc(k < 3, 32'(k * 4), mk_inst(16 + k), c >= 3, 1'b0);
            if (last_acc) k++;
            if (c == 1) begin
                chk("stall_if_ready", 32'(if_ready), 32'd0);
                chk("stall_id_pc1", id_pc, 32'h0);
            end
            if (c == 2) begin
                chk("stall_id_pc2", id_pc, 32'h0);
                chk("stall_id_valid", 32'(id_valid), 32'd1);
            end
        end
        chk("stall_all_accepted", 32'(k), 32'd3);
        chk("stall_q_empty", 32'(exp_q.size()), 32'd0);

        // Flush with maximum occupancy; offered input must vanish
        for (int i = 0; i < 2; i++) cyc(1'b1, 32'h40 + 32'(i * 4), mk_inst(32 + i), 1'b0, 1'b0);
        cyc(1'b1, 32'hBAD0, 32'hDEAD_BEEF, 1'b0, 1'b1);
        exp_fcnt = sat_model(exp_fcnt, MAXDROP);
        chk("flush_id_valid", 32'(id_valid), 32'd0);
        chk("flush_id_inst", id_inst, 32'h0000_0013);
        chk("flush_id_pc", id_pc, 32'h0);
        chk("flush_cnt_max", 32'(flush_cnt), 32'(exp_fcnt));
        chk("flush_if_ready", 32'(if_ready), 32'd1);
        cyc(1'b1, 32'h200, mk_inst(48), 1'b1, 1'b0);
        cyc(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

        // Flush while empty discards nothing
        cyc(1'b1, 32'hBAD4, 32'hDEAD_BEEF, 1'b1, 1'b1);
        chk("flush_empty_cnt", 32'(flush_cnt), 32'(exp_fcnt));
        cyc(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

        // Saturation: preload near the top, then single and maximal flushes
        dut.flush_cnt_reg = 16'hFFFC;
        exp_fcnt = 16'hFFFC;
        for (int i = 0; i < 2; i++) begin
            cyc(1'b1, 32'h300, mk_inst(64), 1'b0, 1'b0);
            cyc(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
            exp_fcnt = sat_model(exp_fcnt, 1);
        end
        chk("sat_cnt_fffe", 32'(flush_cnt), 32'(exp_fcnt));
        for (int j = 0; j < 2; j++) begin
            for (int i = 0; i < 2; i++) cyc(1'b1, 32'h310 + 32'(i * 4), mk_inst(65 + i), 1'b0, 1'b0);
            cyc(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
            exp_fcnt = sat_model(exp_fcnt, MAXDROP);
            chk("sat_cnt_ffff", 32'(flush_cnt), 32'(exp_fcnt));
        end

        // Reset beats flush and transfers while occupied
        for (int i = 0; i < 2; i++) cyc(1'b1, 32'h400 + 32'(i * 4), mk_inst(80 + i), 1'b0, 1'b0);
        rst = 1'b1;
        cyc(1'b1, 32'hDEA0, 32'hDEAD_BEEF, 1'b0, 1'b1);
        rst = 1'b0;
        chk("rst2_id_valid", 32'(id_valid), 32'd0);
        chk("rst2_id_pc", id_pc, 32'h0);
        chk("rst2_flush_cnt", 32'(flush_cnt), 32'd0);
        chk("rst2_if_ready", 32'(if_ready), 32'd1);

        // Traffic resumes after reset
        cyc(1'b1, 32'h500, mk_inst(96), 1'b1, 1'b0);
        cyc(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        cyc(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        chk("end_q_empty", 32'(exp_q.size()), 32'd0);
        chk("end_id_valid", 32'(id_valid), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
